dualmem_stream_packer: RTL

- Upstream write feeder for the 2048 x 64 dual-port buffer memory (11-bit word address, 8 byte-lane write enables).
- Accepts an 8-bit valid/ready byte stream (UART/Ethernet/SD receive paths) and packs bytes little-endian into 64-bit words.
- Issues one registered port write per word, with partial byte-enables on the final word.
- Reports completion, byte count and truncation to the controlling CSR block.

---
 rtl/dualmem_stream_packer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/dualmem_stream_packer.sv
// Byte-stream to 64-bit word packer feeding one write port of the dual-port buffer memory.
// Optional running 16-bit byte checksum output when DUALMEM_STREAM_CSUM_EN is defined.
module dualmem_stream_packer #(
    parameter int ADDR_WIDTH = 11,
    parameter int CNT_WIDTH  = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  mem_en,
    output logic [7:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [63:0]           mem_din,
    output logic                  busy,
    output logic                  done,
    output logic                  truncated,
`ifdef DUALMEM_STREAM_CSUM_EN
    output logic [15:0]           csum,
`endif
    output logic [CNT_WIDTH-1:0]  byte_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              lane_q, lane_d;
    logic [7:0]              mask_q, mask_d;
    logic [63:0]             pack_q, pack_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   word_cnt_q, word_cnt_d;
    logic                    mem_en_q, mem_en_d;
    logic [7:0]              mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [63:0]             mem_din_q, mem_din_d;
    logic                    done_q, done_d;
    logic                    trunc_q, trunc_d;
    logic [CNT_WIDTH-1:0]    byte_count_q, byte_count_d;
`ifdef DUALMEM_STREAM_CSUM_EN
    logic [15:0]             csum_q, csum_d;
`endif

    logic                    accept;
    logic                    issue;
    logic                    cap_hit;
    logic [63:0]             word_w;
    logic [7:0]              mask_w;

    assign accept  = (state_q == RUN) && s_valid;
    assign issue   = accept && ((lane_q == 3'd7) || s_last);
    // word_cnt_q all-ones means the word being issued is the last one that fits
    assign cap_hit = issue && !s_last && (word_cnt_q == '1);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign word_w[8*gi +: 8] = (lane_q == 3'(gi)) ? s_data : pack_q[8*gi +: 8];
            assign mask_w[gi]        = mask_q[gi] | (lane_q == 3'(gi));
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        mask_d       = mask_q;
        pack_d       = pack_q;
        addr_d       = addr_q;
        word_cnt_d   = word_cnt_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 8'h00;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        done_d       = 1'b0;
        trunc_d      = trunc_q;
        byte_count_d = byte_count_q;
`ifdef DUALMEM_STREAM_CSUM_EN
        csum_d       = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = RUN;
                    addr_d       = start_addr;
                    lane_d       = 3'd0;
                    word_cnt_d   = '0;
                    byte_count_d = '0;
                    trunc_d      = 1'b0;
                    pack_d       = 64'd0;
                    mask_d       = 8'h00;
`ifdef DUALMEM_STREAM_CSUM_EN
                    csum_d       = 16'h0000;
`endif
                end
            end
            RUN: begin
                if (accept) begin
                    pack_d       = word_w;
                    mask_d       = mask_w;
                    lane_d       = lane_q + 3'd1;
                    byte_count_d = byte_count_q + CNT_WIDTH'(1);
`ifdef DUALMEM_STREAM_CSUM_EN
                    csum_d       = csum_q + {8'h00, s_data};
`endif
                end
                if (issue) begin
                    mem_en_d   = 1'b1;
                    mem_we_d   = mask_w;
                    mem_addr_d = addr_q;
                    mem_din_d  = word_w;
                    pack_d     = 64'd0;
                    mask_d     = 8'h00;
                    lane_d     = 3'd0;
                    addr_d     = addr_q + ADDR_WIDTH'(1);
                    word_cnt_d = word_cnt_q + ADDR_WIDTH'(1);
                    if (s_last || cap_hit) begin
                        state_d = FLUSH;
                    end
                    if (cap_hit) begin
                        trunc_d = 1'b1;
                    end
                end
            end
            FLUSH: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            lane_q       <= 3'd0;
            mask_q       <= 8'h00;
            pack_q       <= 64'd0;
            addr_q       <= '0;
            word_cnt_q   <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 8'h00;
            mem_addr_q   <= '0;
            mem_din_q    <= 64'd0;
            done_q       <= 1'b0;
            trunc_q      <= 1'b0;
            byte_count_q <= '0;
`ifdef DUALMEM_STREAM_CSUM_EN
            csum_q       <= 16'h0000;
`endif
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            mask_q       <= mask_d;
            pack_q       <= pack_d;
            addr_q       <= addr_d;
            word_cnt_q   <= word_cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            done_q       <= done_d;
            trunc_q      <= trunc_d;
            byte_count_q <= byte_count_d;
`ifdef DUALMEM_STREAM_CSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign s_ready    = (state_q == RUN);
    assign busy       = (state_q != IDLE);
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign done       = done_q;
    assign truncated  = trunc_q;
    assign byte_count = byte_count_q;
`ifdef DUALMEM_STREAM_CSUM_EN
    assign csum       = csum_q;
`endif

endmodule
